el2_sram_init_seq: RTL and testbench

- Sits between the core-side SRAM port (ICCM or DCCM bank bundle) and the SRAM macro bank array.
- After reset, or on request, sweeps every bank address and writes a known data+ECC pattern, so the first reads never return uninitialised data or false ECC errors.
- Outside the sweep it is a transparent pass-through of core requests and SRAM read data.
- One instance per memory (ICCM, DCCM).

---
 rtl/el2_pkg.sv | 12 +
 rtl/el2_sram_init_ctrl.sv | 71 +++++++
 rtl/el2_sram_init_seq.sv | 87 ++++++++
 tb/tb_el2_sram_init_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared type for the SRAM initialisation sequencer.
// Contents:
//   el2_sram_init_state_t : sequencer state (HOLD, INIT, DONE).
package el2_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } el2_sram_init_state_t;

endpackage : el2_pkg

// File: rtl/el2_sram_init_ctrl.sv
// Sequencer FSM and sweep address counter.
// Ports:
//   clk           : core clock
//   rst           : asynchronous active-high reset
//   i_init_req    : single-cycle restart request, honoured only in DONE
//   o_init_active : high while the sweep writes the banks (INIT)
//   o_cnt         : current sweep index
//   o_init_done   : high in DONE only
module el2_sram_init_ctrl
  import el2_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init_req,
  output logic              o_init_active,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_init_done
);

  el2_sram_init_state_t r_state;
  el2_sram_init_state_t w_state_nxt;
  logic [ADDR_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]    w_cnt_nxt;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      HOLD: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
      INIT: begin
        // The last index is written this cycle; the counter wraps to 0 on its own.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_init_req) begin
          w_state_nxt = INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HOLD;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_init_active = (r_state == INIT);
  assign o_init_done   = (r_state == DONE);
  assign o_cnt         = r_cnt;

endmodule : el2_sram_init_ctrl

// File: rtl/el2_sram_init_seq.sv
// SRAM initialisation sequencer between the core bank port and the macro array.
// After reset (or init_req in DONE) every bank index is written with
// INIT_DATA/INIT_ECC; afterwards core requests and read data pass straight through.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   init_req                  : restart pulse (DONE only)
//   init_busy / init_done     : sequencer status
//   core_clken/wren/addr/wr_* : core-side bank requests (bank b at [b*W +: W])
//   core_dout / core_ecc      : read data returned to the core
//   sram_clken/wren/addr/wr_* : requests to the macro banks
//   sram_dout / sram_ecc      : macro read data (1-cycle latency)
module el2_sram_init_seq
  import el2_pkg::*;
#(
  parameter int                  NUM_BANKS = 4,
  parameter int                  ADDR_W    = 10,
  parameter int                  DATA_W    = 32,
  parameter int                  ECC_W     = 7,
  parameter logic [DATA_W-1:0]   INIT_DATA = '0,
  parameter logic [ECC_W-1:0]    INIT_ECC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_req,
  output logic                          init_busy,
  output logic                          init_done,
  input  logic [NUM_BANKS-1:0]          core_clken,
  input  logic [NUM_BANKS-1:0]          core_wren,
  input  logic [NUM_BANKS*ADDR_W-1:0]   core_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   core_wr_data,
  input  logic [NUM_BANKS*ECC_W-1:0]    core_wr_ecc,
  output logic [NUM_BANKS*DATA_W-1:0]   core_dout,
  output logic [NUM_BANKS*ECC_W-1:0]    core_ecc,
  output logic [NUM_BANKS-1:0]          sram_clken,
  output logic [NUM_BANKS-1:0]          sram_wren,
  output logic [NUM_BANKS*ADDR_W-1:0]   sram_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   sram_wr_data,
  output logic [NUM_BANKS*ECC_W-1:0]    sram_wr_ecc,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_dout,
  input  logic [NUM_BANKS*ECC_W-1:0]    sram_ecc
);

  logic              w_active;
  logic              w_done;
  logic [ADDR_W-1:0] w_cnt;

  el2_sram_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_init_req    (init_req),
    .o_init_active (w_active),
    .o_cnt         (w_cnt),
    .o_init_done   (w_done)
  );

  assign init_busy = ~w_done;
  assign init_done = w_done;

  // Per-bank mux: sweep pattern in INIT, core pass-through in DONE, idle zeros in HOLD.
  // Core requests during the sweep are dropped, not queued.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign sram_clken[b] = w_active | (w_done & core_clken[b]);
    assign sram_wren[b]  = w_active | (w_done & core_wren[b]);
    assign sram_addr[b*ADDR_W +: ADDR_W] =
      w_active ? w_cnt : (w_done ? core_addr[b*ADDR_W +: ADDR_W] : '0);
    assign sram_wr_data[b*DATA_W +: DATA_W] =
      w_active ? INIT_DATA : (w_done ? core_wr_data[b*DATA_W +: DATA_W] : '0);
    assign sram_wr_ecc[b*ECC_W +: ECC_W] =
      w_active ? INIT_ECC : (w_done ? core_wr_ecc[b*ECC_W +: ECC_W] : '0);
    assign core_dout[b*DATA_W +: DATA_W] =
      w_done ? sram_dout[b*DATA_W +: DATA_W] : '0;
    assign core_ecc[b*ECC_W +: ECC_W] =
      w_done ? sram_ecc[b*ECC_W +: ECC_W] : '0;
  end

  // Core must stay off the banks until init_done; such accesses are lost.
  a_no_core_while_busy : assert property (
    @(posedge clk) disable iff (rst) !(init_busy && (core_clken != '0))
  ) else $warning("core access dropped while SRAM init busy");

  a_wren_needs_clken : assert property (
    @(posedge clk) disable iff (rst) ((sram_wren & ~sram_clken) == '0)
  ) else $error("sram_wren asserted without sram_clken");

endmodule : el2_sram_init_seq

// File: tb/tb_el2_sram_init_seq.sv
module tb_el2_sram_init_seq;

  localparam int NB = 4;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int DEPTH = 1 << AW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                init_req = 1'b0;
  logic                init_busy, init_done;
  logic [NB-1:0]       core_clken = '0, core_wren = '0;
  logic [NB*AW-1:0]    core_addr = '0;
  logic [NB*DW-1:0]    core_wr_data = '0;
  logic [NB*EW-1:0]    core_wr_ecc = '0;
  logic [NB*DW-1:0]    core_dout;
  logic [NB*EW-1:0]    core_ecc;
  logic [NB-1:0]       sram_clken, sram_wren;
  logic [NB*AW-1:0]    sram_addr;
  logic [NB*DW-1:0]    sram_wr_data;
  logic [NB*EW-1:0]    sram_wr_ecc;
  logic [NB*DW-1:0]    sram_dout = '0;
  logic [NB*EW-1:0]    sram_ecc = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  el2_sram_init_seq #(
    .NUM_BANKS (NB), .ADDR_W (AW), .DATA_W (DW), .ECC_W (EW),
    .INIT_DATA ('0), .INIT_ECC ('0)
  ) dut (
    .clk (clk), .rst (rst), .init_req (init_req),
    .init_busy (init_busy), .init_done (init_done),
    .core_clken (core_clken), .core_wren (core_wren), .core_addr (core_addr),
    .core_wr_data (core_wr_data), .core_wr_ecc (core_wr_ecc),
    .core_dout (core_dout), .core_ecc (core_ecc),
    .sram_clken (sram_clken), .sram_wren (sram_wren), .sram_addr (sram_addr),
    .sram_wr_data (sram_wr_data), .sram_wr_ecc (sram_wr_ecc),
    .sram_dout (sram_dout), .sram_ecc (sram_ecc)
  );

  // Macro model: per-bank array, 1-cycle read latency, read data holds until next read.
  logic [DW-1:0] mem_d [NB][DEPTH];
  logic [EW-1:0] mem_e [NB][DEPTH];

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mem_d[b][a] = 32'hA5A5_0000 | 32'(b * 256 + a);
        mem_e[b][a] = 7'h55;
      end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (sram_clken[b]) begin
        if (sram_wren[b]) begin
          mem_d[b][sram_addr[b*AW +: AW]] <= sram_wr_data[b*DW +: DW];
          mem_e[b][sram_addr[b*AW +: AW]] <= sram_wr_ecc[b*EW +: EW];
        end else begin
          sram_dout[b*DW +: DW] <= mem_d[b][sram_addr[b*AW +: AW]];
          sram_ecc[b*EW +: EW]  <= mem_e[b][sram_addr[b*AW +: AW]];
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    core_clken   = '0;
    core_wren    = '0;
    core_addr    = '0;
    core_wr_data = '0;
    core_wr_ecc  = '0;
    init_req     = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    check({tag, " hold clken"}, 128'(sram_clken), 128'h0);
    check({tag, " hold wren"},  128'(sram_wren),  128'h0);
    check({tag, " hold addr"},  128'(sram_addr),  128'h0);
    check({tag, " hold wdata"}, 128'(sram_wr_data), 128'h0);
    check({tag, " hold busy"},  128'(init_busy),  128'h1);
    check({tag, " hold done"},  128'(init_done),  128'h0);
  endtask

  // Expects INIT with cnt=0 in the current cycle. Optionally pokes a core
  // request (bank0 addr 3) at index poke_k and an init_req pulse at req_k.
  task automatic run_sweep(input string tag, input int poke_k, input int req_k);
    logic [3:0] kk;
    for (int k = 0; k < DEPTH; k++) begin
      kk = k[3:0];
      core_clken = (k == poke_k) ? 4'h1 : 4'h0;
      core_addr  = (k == poke_k) ? 16'h0003 : 16'h0000;
      init_req   = (k == req_k);
      #1;
      check($sformatf("%s sweep clken k=%0d", tag, k), 128'(sram_clken), 128'hF);
      check($sformatf("%s sweep wren k=%0d", tag, k),  128'(sram_wren),  128'hF);
      check($sformatf("%s sweep addr k=%0d", tag, k),  128'(sram_addr),  128'({kk, kk, kk, kk}));
      check($sformatf("%s sweep data k=%0d", tag, k),  128'(sram_wr_data), 128'h0);
      check($sformatf("%s sweep ecc k=%0d", tag, k),   128'(sram_wr_ecc),  128'h0);
      check($sformatf("%s sweep busy k=%0d", tag, k),  128'(init_busy),  128'h1);
      check($sformatf("%s sweep dout k=%0d", tag, k),  128'(core_dout),  128'h0);
      check($sformatf("%s sweep cecc k=%0d", tag, k),  128'(core_ecc),   128'h0);
      wait_cycle();
    end
    clear_core();
    #1;
    check({tag, " done after sweep"}, 128'(init_done), 128'h1);
    check({tag, " busy after sweep"}, 128'(init_busy), 128'h0);
  endtask

  typedef struct {
    logic [3:0]   clken;
    logic [3:0]   wren;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [27:0]  wecc;
    logic         chk_rd;
    logic [127:0] exp_dout;
    logic [27:0]  exp_ecc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Watchdog: the directed sequence is a few hundred cycles.
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{clken: 4'b0100, wren: 4'b0100, addr: 16'h0500,
                wdata: {32'h0, 32'hDEADBEEF, 64'h0}, wecc: {7'h0, 7'h2A, 14'h0},
                chk_rd: 1'b0, exp_dout: '0, exp_ecc: '0};
    vecs[1] = '{clken: 4'b0100, wren: 4'b0000, addr: 16'h0500,
                wdata: '0, wecc: '0, chk_rd: 1'b0, exp_dout: '0, exp_ecc: '0};
    vecs[2] = '{clken: 4'b0000, wren: 4'b0000, addr: 16'h0000,
                wdata: '0, wecc: '0, chk_rd: 1'b1,
                exp_dout: {32'h0, 32'hDEADBEEF, 64'h0}, exp_ecc: {7'h0, 7'h2A, 14'h0}};
    vecs[3] = '{clken: 4'hF, wren: 4'hF, addr: 16'h9999,
                wdata: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                wecc: {7'h04, 7'h03, 7'h02, 7'h01}, chk_rd: 1'b0, exp_dout: '0, exp_ecc: '0};
    vecs[4] = '{clken: 4'hF, wren: 4'h0, addr: 16'h9909,
                wdata: '0, wecc: '0, chk_rd: 1'b0, exp_dout: '0, exp_ecc: '0};
    vecs[5] = '{clken: 4'h0, wren: 4'h0, addr: 16'h0000, wdata: '0, wecc: '0, chk_rd: 1'b1,
                exp_dout: {32'h44444444, 32'h33333333, 32'h00000000, 32'h11111111},
                exp_ecc: {7'h04, 7'h03, 7'h00, 7'h01}};
    vecs[6] = '{clken: 4'b1100, wren: 4'h0, addr: 16'h5500,
                wdata: '0, wecc: '0, chk_rd: 1'b0, exp_dout: '0, exp_ecc: '0};
    vecs[7] = '{clken: 4'h0, wren: 4'h0, addr: 16'h0000, wdata: '0, wecc: '0, chk_rd: 1'b1,
                exp_dout: {32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h11111111},
                exp_ecc: {7'h00, 7'h2A, 7'h00, 7'h01}};

    // Reset state, HOLD, then first sweep with a dropped core request at
    // cnt=3 and an ignored init_req at cnt=4.
    repeat (2) @(posedge clk);
    #1;
    check_hold("reset");
    rst = 1'b0;
    #1;
    check_hold("post-release");
    wait_cycle();
    run_sweep("first", 3, 4);
    repeat (2) begin
      wait_cycle();
      check("no second sweep", 128'(init_done), 128'h1);
    end

    // DONE pass-through table.
    for (int i = 0; i < 8; i++) begin
      core_clken   = vecs[i].clken;
      core_wren    = vecs[i].wren;
      core_addr    = vecs[i].addr;
      core_wr_data = vecs[i].wdata;
      core_wr_ecc  = vecs[i].wecc;
      #1;
      check($sformatf("vec%0d sram_clken", i), 128'(sram_clken), 128'(vecs[i].clken));
      check($sformatf("vec%0d sram_wren", i),  128'(sram_wren),  128'(vecs[i].wren));
      check($sformatf("vec%0d sram_addr", i),  128'(sram_addr),  128'(vecs[i].addr));
      check($sformatf("vec%0d sram_wdata", i), sram_wr_data,     vecs[i].wdata);
      check($sformatf("vec%0d sram_wecc", i),  128'(sram_wr_ecc), 128'(vecs[i].wecc));
      if (vecs[i].chk_rd) begin
        check($sformatf("vec%0d core_dout", i), core_dout,        vecs[i].exp_dout);
        check($sformatf("vec%0d core_ecc", i),  128'(core_ecc),   128'(vecs[i].exp_ecc));
      end
      wait_cycle();
    end
    clear_core();

    // init_req in DONE with a simultaneous write to bank0 addr 7.
    init_req     = 1'b1;
    core_clken   = 4'h1;
    core_wren    = 4'h1;
    core_addr    = 16'h0007;
    core_wr_data = 128'hCAFEF00D;
    core_wr_ecc  = 28'h11;
    #1;
    check("req write wren", 128'(sram_wren), 128'h1);
    check("req write addr", 128'(sram_addr), 128'h0007);
    check("req write data", sram_wr_data, 128'hCAFEF00D);
    check("req cycle done", 128'(init_done), 128'h1);
    wait_cycle();
    clear_core();
    check("req write landed", 128'(mem_d[0][7]), 128'hCAFEF00D);
    run_sweep("restart", -1, -1);
    core_clken = 4'h1;
    core_addr  = 16'h0007;
    wait_cycle();
    clear_core();
    #1;
    check("addr7 reinit data", 128'(core_dout[31:0]), 128'h0);
    check("addr7 reinit ecc",  128'(core_ecc[6:0]),   128'h0);

    // Reset asserted mid-sweep at cnt=9.
    init_req = 1'b1;
    wait_cycle();
    init_req = 1'b0;
    repeat (9) wait_cycle();
    check("pre-reset addr", 128'(sram_addr), 128'h9999);
    rst = 1'b1;
    #1;
    check_hold("midreset");
    wait_cycle();
    rst = 1'b0;
    #1;
    check_hold("midreset-release");
    wait_cycle();
    run_sweep("after-reset", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_el2_sram_init_seq
